alu_share_arbiter: RTL and testbench

//   Shares one execution ALU between two requesters (req0/req1) using valid/ready handshakes.

---
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter : round-robin sharing of one EX-stage ALU between two
//                     issue ports, with multi-cycle hold for MUL/DIV.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int WORD       = 32,
  parameter int ALUOP      = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WORD-1:0]  req0_rs1_i,
  input  logic [WORD-1:0]  req0_rs2_i,
  input  logic [ALUOP-1:0] req0_aluop_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WORD-1:0]  req1_rs1_i,
  input  logic [WORD-1:0]  req1_rs2_i,
  input  logic [ALUOP-1:0] req1_aluop_i,
  output logic [WORD-1:0]  alu_rs1_o,
  output logic [WORD-1:0]  alu_rs2_o,
  output logic [ALUOP-1:0] alu_aluop_o,
  input  logic [WORD-1:0]  alu_data_i,
  input  logic             alu_zerof_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WORD-1:0]  rsp_data_o,
  output logic             rsp_zerof_o
);

  localparam int                 CNT_W   = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0]   MD_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [ALUOP-1:0]   OP_MUL  = ALUOP'(2);
  localparam logic [ALUOP-1:0]   OP_DIV  = ALUOP'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant_id;
  logic             accept;
  logic [WORD-1:0]  sel_rs1, sel_rs2;
  logic [ALUOP-1:0] sel_op;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant_id = req1_valid_i;
    if (req0_valid_i && req1_valid_i) grant_id = ~last_grant;
    accept       = (state == IDLE) && (req0_valid_i || req1_valid_i);
    req0_ready_o = accept && !grant_id;
    req1_ready_o = accept && grant_id;
    sel_rs1      = grant_id ? req1_rs1_i   : req0_rs1_i;
    sel_rs2      = grant_id ? req1_rs2_i   : req0_rs2_i;
    sel_op       = grant_id ? req1_aluop_i : req0_aluop_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant  <= 1'b1;
      cnt         <= '0;
      alu_rs1_o   <= '0;
      alu_rs2_o   <= '0;
      alu_aluop_o <= '0;
      rsp_id_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zerof_o <= 1'b0;
    end else begin
      if (accept) begin
        alu_rs1_o   <= sel_rs1;
        alu_rs2_o   <= sel_rs2;
        alu_aluop_o <= sel_op;
        rsp_id_o    <= grant_id;
        last_grant  <= grant_id;
        cnt         <= (sel_op == OP_MUL || sel_op == OP_DIV) ? MD_LOAD : '0;
      end
      if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_data_o  <= alu_data_i;
          rsp_zerof_o <= alu_zerof_i;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small behavioural ALU.
`default_nettype none

module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        v0, v1, r0, r1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic [31:0] alu_a, alu_b, alu_d;
  logic [3:0]  alu_op;
  logic        alu_z;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_z;
  logic [31:0] rsp_d;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WORD(32), .ALUOP(4), .MULDIV_LAT(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_rs1_i(a0), .req0_rs2_i(b0), .req0_aluop_i(op0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_rs1_i(a1), .req1_rs2_i(b1), .req1_aluop_i(op1),
    .alu_rs1_o(alu_a), .alu_rs2_o(alu_b), .alu_aluop_o(alu_op),
    .alu_data_i(alu_d), .alu_zerof_i(alu_z),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_d), .rsp_zerof_o(rsp_z)
  );

  always_comb begin
    alu_d = 32'hDEAD_BEEF;
    case (alu_op)
      4'h8: alu_d = alu_a + alu_b;
      4'h1: alu_d = alu_a - alu_b;
      4'h2: alu_d = alu_a * alu_b;
      4'h3: alu_d = (alu_b != 0) ? alu_a / alu_b : 32'hFFFF_FFFF;
      default: alu_d = 32'hDEAD_BEEF;
    endcase
    alu_z = (alu_d == 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    v0 = 0; v1 = 0; rsp_ready = 1;
    rstn = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; v0 = 0; v1 = 0; rsp_ready = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    #12;
    tests++;
    if ({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_z, r0, r1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: alu_a=%h alu_b=%h op=%h rv=%b id=%b d=%h z=%b r0=%b r1=%b required all 0",
               alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_z, r0, r1);
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    v0 = 1; a0 = 5; b0 = 3; op0 = 4'h8; rsp_ready = 1;
    #1;
    tests++;
    if ({r0, r1} !== 2'b10) begin
      fails++; $display("FAIL add_ready: r0r1=%b required 10", {r0, r1});
    end
    @(negedge clk);
    v0 = 0;
    #1;
    tests++;
    if ({alu_a, alu_b, alu_op, rsp_valid} !== {32'd5, 32'd3, 4'h8, 1'b0}) begin
      fails++; $display("FAIL add_exec: a=%0d b=%0d op=%h rv=%b required 5 3 8 0", alu_a, alu_b, alu_op, rsp_valid);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_d, rsp_z} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin
      fails++; $display("FAIL add_rsp: rv=%b id=%b d=%0d z=%b required 1 0 8 0", rsp_valid, rsp_id, rsp_d, rsp_z);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, alu_a, alu_op} !== {1'b0, 32'd5, 4'h8}) begin
      fails++; $display("FAIL add_done: rv=%b a=%0d op=%h required 0 5 8", rsp_valid, alu_a, alu_op);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    v0 = 1; a0 = 7; b0 = 7; op0 = 4'h1;
    v1 = 1; a1 = 7; b1 = 7; op1 = 4'h1;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({r0, r1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL rr_grant[%0d]: r0r1=%b required %b", k, {r0, r1}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      tests++;
      if ({r0, r1, rsp_valid} !== 3'b000) begin
        fails++; $display("FAIL rr_exec[%0d]: r0 r1 rv=%b required 000", k, {r0, r1, rsp_valid});
      end
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_id, rsp_d, rsp_z, r0, r1} !== {1'b1, (k % 2 == 1), 32'd0, 1'b1, 2'b00}) begin
        fails++; $display("FAIL rr_rsp[%0d]: rv=%b id=%b d=%0d z=%b r0r1=%b required 1 %0d 0 1 00",
                          k, rsp_valid, rsp_id, rsp_d, rsp_z, {r0, r1}, k % 2);
      end
      @(negedge clk);
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_mul_and_stall();
    // last winner is req1; req1 alone issues MUL, req0 then waits behind it
    v1 = 1; a1 = 6; b1 = 7; op1 = 4'h2; rsp_ready = 0;
    #1;
    tests++;
    if ({r0, r1} !== 2'b01) begin
      fails++; $display("FAIL mul_ready: r0r1=%b required 01", {r0, r1});
    end
    @(negedge clk);
    v1 = 0; v0 = 1; a0 = 1; b0 = 2; op0 = 4'h8;
    for (int i = 1; i <= 4; i++) begin
      #1;
      tests++;
      if ({r0, r1, rsp_valid, alu_op} !== {3'b000, 4'h2}) begin
        fails++; $display("FAIL mul_exec[%0d]: r0 r1 rv=%b op=%h required 000 2", i, {r0, r1, rsp_valid}, alu_op);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if ({rsp_valid, rsp_id, rsp_d, rsp_z, r0, r1} !== {1'b1, 1'b1, 32'd42, 1'b0, 2'b00}) begin
        fails++; $display("FAIL mul_stall[%0d]: rv=%b id=%b d=%0d z=%b r0r1=%b required 1 1 42 0 00",
                          i, rsp_valid, rsp_id, rsp_d, rsp_z, {r0, r1});
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    #1;
    tests++;
    if ({rsp_valid, r0, r1} !== 3'b010) begin
      fails++; $display("FAIL resume: rv r0 r1=%b required 010", {rsp_valid, r0, r1});
    end
    @(negedge clk);
    v0 = 0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_d} !== {1'b1, 1'b0, 32'd3}) begin
      fails++; $display("FAIL resume_rsp: rv=%b id=%b d=%0d required 1 0 3", rsp_valid, rsp_id, rsp_d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    // last winner is req0, so with both valid req1 takes the MUL
    v0 = 1; a0 = 2; b0 = 2; op0 = 4'h8;
    v1 = 1; a1 = 9; b1 = 9; op1 = 4'h2;
    rsp_ready = 1;
    #1;
    tests++;
    if ({r0, r1} !== 2'b01) begin
      fails++; $display("FAIL rst_mid_grant: r0r1=%b required 01", {r0, r1});
    end
    @(negedge clk);
    v0 = 0; v1 = 0;
    #2 rstn = 0;
    #1;
    tests++;
    if ({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_z} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: a=%h b=%h op=%h rv=%b id=%b d=%h z=%b required all 0",
                        alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_z);
    end
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL rst_no_rsp[%0d]: rv=%b required 0", i, rsp_valid);
      end
    end
    v0 = 1; v1 = 1;
    #1;
    tests++;
    if ({r0, r1} !== 2'b10) begin
      fails++; $display("FAIL rst_regrant: r0r1=%b required 10", {r0, r1});
    end
    @(negedge clk);
    v0 = 0; v1 = 0;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_id, rsp_d} !== {1'b1, 1'b0, 32'd4}) begin
      fails++; $display("FAIL rst_regrant_rsp: rv=%b id=%b d=%0d required 1 0 4", rsp_valid, rsp_id, rsp_d);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_mul_and_stall();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
